prio_multi_fifo: RTL and testbench

Parametrised multi-class priority FIFO for the switch ingress path. It replaces the single fixed 21-bit x32 origin FIFO with NUM_PRIO independent circular buffers of inferred storage. A read always pops the highest-priority non-empty class and returns the word with a registered valid strobe. Per-class occupancy and overflow/underflow flags feed the scheduler and the debug counters.

---
 rtl/prio_multi_fifo_pkg.sv | 27 ++
 rtl/prio_multi_fifo_if.sv | 45 ++++
 rtl/prio_multi_fifo_lane.sv | 76 +++++++
 rtl/prio_multi_fifo.sv | 125 ++++++++++++
 tb/tb_prio_multi_fifo.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/prio_multi_fifo_pkg.sv
// -----------------------------------------------------------------------------
// prio_fifo_pkg
// Shared definitions for the multi-class priority FIFO:
//   clog2      - ceiling log2, used to size pointers and class indices
//   *_DEF      - default geometry (21-bit payload, 32 entries, 4 classes)
//   cnt_off    - bit offset of class i inside the packed occupancy bus
// -----------------------------------------------------------------------------
package prio_fifo_pkg;

    localparam int DATA_W_DEF   = 21;
    localparam int DEPTH_DEF    = 32;
    localparam int NUM_PRIO_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_off(input int i, input int cnt_w);
        return i * cnt_w;
    endfunction

endpackage

// File: rtl/prio_multi_fifo_if.sv
// -----------------------------------------------------------------------------
// prio_multi_fifo_if
// Handshake/status bundle of the priority FIFO.
//   we, wr_prio, din      - write request, destination class, payload
//   re                    - read request (pops highest-priority class)
//   dout, dout_prio       - read payload and its source class
//   valid                 - one-cycle strobe qualifying dout/dout_prio
//   empty, full, count    - aggregate empty, per-class full, packed occupancy
//   ovf, unf              - dropped-write / empty-read pulses
// master drives requests (producer/scheduler side), slave is the FIFO.
// -----------------------------------------------------------------------------
interface prio_multi_fifo_if
    import prio_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_PRIO = NUM_PRIO_DEF,
    localparam int PRIO_W  = clog2(NUM_PRIO),
    localparam int CNT_W   = clog2(DEPTH) + 1
);

    logic                      we;
    logic [PRIO_W-1:0]         wr_prio;
    logic [DATA_W-1:0]         din;
    logic                      re;
    logic [DATA_W-1:0]         dout;
    logic [PRIO_W-1:0]         dout_prio;
    logic                      valid;
    logic                      empty;
    logic [NUM_PRIO-1:0]       full;
    logic [NUM_PRIO*CNT_W-1:0] count;
    logic                      ovf;
    logic                      unf;

    modport master (
        output we, wr_prio, din, re,
        input  dout, dout_prio, valid, empty, full, count, ovf, unf
    );

    modport slave (
        input  we, wr_prio, din, re,
        output dout, dout_prio, valid, empty, full, count, ovf, unf
    );

endinterface

// File: rtl/prio_multi_fifo_lane.sv
// -----------------------------------------------------------------------------
// prio_fifo_lane
// One class of the priority FIFO: circular buffer with wrap-bit pointers and a
// registered read port.
//   clk, rst   - clock, synchronous active-high reset (pointers/read reg only)
//   push_i     - store wdata_i at the tail (caller guarantees not full)
//   wdata_i    - payload
//   pop_i      - load head word into rdata_o (caller guarantees not empty)
//   rdata_o    - last popped word, holds between pops
//   full_o     - pointers differ only in the wrap bit
//   empty_o    - pointers equal
//   count_o    - occupancy, wr - rd modulo 2^CNT_W
// -----------------------------------------------------------------------------
module prio_fifo_lane
    import prio_fifo_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    localparam int CNT_W  = clog2(DEPTH) + 1,
    localparam int AW     = CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
            rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is never reset; a write suppressed by reset is simply lost
    // because the write pointer does not advance over it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/prio_multi_fifo.sv
// -----------------------------------------------------------------------------
// prio_multi_fifo
// NUM_PRIO independent FIFO lanes behind a fixed-priority reader. A read pops
// the lowest-index non-empty class; the word appears one cycle later with a
// one-cycle valid strobe.
//   clk, rst - clock, synchronous active-high reset
//   bus      - prio_multi_fifo_if.slave: we/wr_prio/din, re, dout/dout_prio/
//              valid, empty, full[NUM_PRIO], count[NUM_PRIO*CNT_W], ovf, unf
// -----------------------------------------------------------------------------
module prio_multi_fifo
    import prio_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_PRIO = NUM_PRIO_DEF,
    localparam int PRIO_W  = clog2(NUM_PRIO),
    localparam int CNT_W   = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    prio_multi_fifo_if.slave  bus
);

    logic [NUM_PRIO-1:0]       lane_push;
    logic [NUM_PRIO-1:0]       lane_pop;
    logic [NUM_PRIO-1:0]       lane_full;
    logic [NUM_PRIO-1:0]       lane_empty;
    logic [CNT_W-1:0]          lane_cnt   [NUM_PRIO];
    logic [DATA_W-1:0]         lane_rdata [NUM_PRIO];
    logic [NUM_PRIO*CNT_W-1:0] cnt_bus;

    logic              rd_hit;
    logic [PRIO_W-1:0] rd_sel;

    logic              valid_q, valid_d;
    logic [PRIO_W-1:0] sel_q, sel_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    for (genvar g = 0; g < NUM_PRIO; g++) begin : g_lane
        prio_fifo_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .push_i  (lane_push[g]),
            .wdata_i (bus.din),
            .pop_i   (lane_pop[g]),
            .rdata_o (lane_rdata[g]),
            .full_o  (lane_full[g]),
            .empty_o (lane_empty[g]),
            .count_o (lane_cnt[g])
        );
    end

    // Fixed-priority select on the pre-edge state: scanning downward lets the
    // lowest non-empty index win.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        for (int i = NUM_PRIO - 1; i >= 0; i--) begin
            if (!lane_empty[i]) begin
                rd_hit = 1'b1;
                rd_sel = PRIO_W'(i);
            end
        end
    end

    // Write demux and read strobes. Fullness is the pre-edge value, so a write
    // to a full class is dropped even when the same edge pops that class.
    // A wr_prio outside 0..NUM_PRIO-1 matches no lane and is dropped too.
    always_comb begin
        lane_push = '0;
        lane_pop  = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            if (bus.we && (bus.wr_prio == PRIO_W'(i)) && !lane_full[i]) begin
                lane_push[i] = 1'b1;
            end
            if (bus.re && rd_hit && (rd_sel == PRIO_W'(i))) begin
                lane_pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = bus.re && rd_hit;
        sel_d   = (bus.re && rd_hit) ? rd_sel : sel_q;
        ovf_d   = bus.we && (lane_push == '0);
        unf_d   = bus.re && !rd_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        cnt_bus = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            cnt_bus[cnt_off(i, CNT_W) +: CNT_W] = lane_cnt[i];
        end
    end

    // dout is the read register of the lane last popped; both the lane data
    // and sel_q only change on a pop, so dout holds while valid is low.
    assign bus.dout      = lane_rdata[sel_q];
    assign bus.dout_prio = sel_q;
    assign bus.valid     = valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.empty     = &lane_empty;
    assign bus.full      = lane_full;
    assign bus.count     = cnt_bus;

endmodule

// File: tb/tb_prio_multi_fifo.sv
// -----------------------------------------------------------------------------
// tb_prio_multi_fifo
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a queue-based reference model of the priority FIFO.
// -----------------------------------------------------------------------------
module tb_prio_multi_fifo;
    import prio_fifo_pkg::*;

    localparam int DATA_W   = DATA_W_DEF;
    localparam int DEPTH    = DEPTH_DEF;
    localparam int NUM_PRIO = NUM_PRIO_DEF;
    localparam int PRIO_W   = clog2(NUM_PRIO);
    localparam int CNT_W    = clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prio_multi_fifo_if #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_PRIO (NUM_PRIO)
    ) bus ();

    prio_multi_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_PRIO (NUM_PRIO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per class plus the expected output registers.
    logic [DATA_W-1:0] mq [NUM_PRIO][$];
    logic [DATA_W-1:0] e_dout  = '0;
    int                e_prio  = 0;
    logic              e_valid = 1'b0;
    logic              e_ovf   = 1'b0;
    logic              e_unf   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_total();
        int t;
        t = 0;
        for (int c = 0; c < NUM_PRIO; c++) t += mq[c].size();
        return t;
    endfunction

    task automatic check_all();
        logic [NUM_PRIO-1:0] e_full;
        e_full = '0;
        for (int c = 0; c < NUM_PRIO; c++) begin
            e_full[c] = (mq[c].size() == DEPTH);
            chk("count", 64'(bus.count[c*CNT_W +: CNT_W]), 64'(mq[c].size()));
        end
        chk("valid", 64'(bus.valid), 64'(e_valid));
        chk("dout", 64'(bus.dout), 64'(e_dout));
        chk("dout_prio", 64'(bus.dout_prio), 64'(e_prio));
        chk("ovf", 64'(bus.ovf), 64'(e_ovf));
        chk("unf", 64'(bus.unf), 64'(e_unf));
        chk("empty", 64'(bus.empty), 64'(model_total() == 0));
        chk("full", 64'(bus.full), 64'(e_full));
    endtask

    // One clock: drive inputs, advance the model on the pre-edge state, check.
    task automatic cyc(input logic w, input int p, input logic [DATA_W-1:0] d,
                       input logic r, input logic rs);
        int  sel;
        bit  wr_ok;
        bus.we      = w;
        bus.wr_prio = PRIO_W'(p);
        bus.din     = d;
        bus.re      = r;
        rst         = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            for (int c = 0; c < NUM_PRIO; c++) mq[c].delete();
            e_dout  = '0;
            e_prio  = 0;
            e_valid = 1'b0;
            e_ovf   = 1'b0;
            e_unf   = 1'b0;
        end else begin
            sel = -1;
            for (int c = NUM_PRIO - 1; c >= 0; c--) begin
                if (mq[c].size() != 0) sel = c;
            end
            wr_ok = w && (p < NUM_PRIO) && (mq[p].size() < DEPTH);
            e_valid = r && (sel >= 0);
            e_unf   = r && (sel < 0);
            e_ovf   = w && !wr_ok;
            if (r && sel >= 0) begin
                e_dout = mq[sel].pop_front();
                e_prio = sel;
            end
            if (wr_ok) mq[p].push_back(d);
        end
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.we      = 1'b0;
        bus.wr_prio = '0;
        bus.din     = '0;
        bus.re      = 1'b0;

        // Reset, idle, then a read from an empty FIFO.
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        idle();
        idle();
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("unf_pulse", 64'(bus.unf), 64'd1);
        idle();

        // Single word through class 2.
        cyc(1'b1, 2, 21'h1A2B3, 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("single_dout", 64'(bus.dout), 64'h1A2B3);
        chk("single_prio", 64'(bus.dout_prio), 64'd2);
        idle();

        // Strict priority across classes 3, 1, 0.
        cyc(1'b1, 3, 21'h0000A, 1'b0, 1'b0);
        cyc(1'b1, 1, 21'h0000B, 1'b0, 1'b0);
        cyc(1'b1, 0, 21'h0000C, 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("prio_first", 64'(bus.dout), 64'h0000C);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("prio_last", 64'(bus.dout_prio), 64'd3);
        idle();

        // Fill class 1, overflow it, then simultaneous write+read on it.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1, DATA_W'(i), 1'b0, 1'b0);
        chk("full1", 64'(bus.full[1]), 64'd1);
        cyc(1'b1, 1, 21'h15555, 1'b0, 1'b0);
        chk("ovf_full", 64'(bus.ovf), 64'd1);
        cyc(1'b1, 1, 21'h0AAAA, 1'b1, 1'b0);
        chk("ovf_rw", 64'(bus.ovf), 64'd1);
        chk("rw_dout", 64'(bus.dout), 64'd0);

        // Drain, then 100 interleaved words through class 0 to exercise wrap.
        for (int i = 0; i < 4 * DEPTH && model_total() != 0; i++) cyc(1'b0, 0, '0, 1'b1, 1'b0);
        cyc(1'b1, 0, DATA_W'(0), 1'b0, 1'b0);
        for (int i = 1; i < 100; i++) cyc(1'b1, 0, DATA_W'(i), 1'b1, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("wrap_last", 64'(bus.dout), 64'd99);
        idle();

        // Reset while class 0 holds five words and a read is requested.
        for (int i = 0; i < 5; i++) cyc(1'b1, 0, DATA_W'(i + 'h40), 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        cyc(1'b1, 0, 21'h7, 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("post_rst", 64'(bus.dout), 64'h7);

        // Randomized traffic with phases biased toward filling or draining.
        for (int blk = 0; blk < 20; blk++) begin
            int wp, rp;
            wp = $urandom_range(20, 95);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                logic w, r, rs;
                int   p;
                w  = ($urandom_range(0, 99) < wp);
                r  = ($urandom_range(0, 99) < rp);
                rs = ($urandom_range(0, 599) == 0);
                p  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, NUM_PRIO - 1);
                cyc(w, p, DATA_W'($urandom), r, rs);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
